// File: rtl/axis_pkt_sched_pkg.sv
// Shared types and width helpers for the AXI-Stream packet scheduler.
package axis_pkt_sched_pkg;

  localparam int GAP_W = 16;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } sched_state_t;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int width_of(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/axis_pkt_sched_rr_arb.sv
// Combinational round-robin arbiter: first request at or after i_ptr, searched cyclically.
module rr_arb
  import axis_pkt_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = width_of(N - 1)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  input  logic         i_en,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  logic [W-1:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int i = 0; i < N; i++) begin
      w_j = W'((int'(i_ptr) + i) % N);
      if (!o_any && i_en && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/axis_pkt_sched.sv
// Round-robin scheduler sharing one packet generator between N_REQ requesters,
// with MTU length checking, inter-packet gap and a done timeout.
module axis_pkt_sched
  import axis_pkt_sched_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int MTU_BYTES    = 1500,
  parameter int USER_WIDTH   = 8,
  parameter int DONE_TIMEOUT = 65535,
  parameter int LEN_W        = width_of(MTU_BYTES),
  parameter int SRC_W        = width_of(N_REQ - 1)
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic                        enable,
  input  logic [15:0]                 cfg_gap,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*LEN_W-1:0]      req_len,
  input  logic [N_REQ*USER_WIDTH-1:0] req_user,
  output logic                        gen_req,
  input  logic                        gen_ack,
  input  logic                        gen_done,
  output logic [LEN_W-1:0]            gen_len,
  output logic [USER_WIDTH-1:0]       gen_user,
  output logic [SRC_W-1:0]            gen_src,
  output logic                        err_len,
  output logic [SRC_W-1:0]            err_src,
  output logic                        timeout,
  output logic [31:0]                 pkt_count
);

  localparam int TMR_W = width_of(DONE_TIMEOUT - 1);

  sched_state_t r_state, w_state_nxt;
  logic [SRC_W-1:0]      r_rr_ptr, w_idx, r_gen_src, r_err_src;
  logic [N_REQ-1:0]      w_gnt;
  logic                  w_any, w_arb_en, w_len_ok, w_legal;
  logic                  w_done_evt, w_tmo_evt, w_end, w_tmr_tc, w_busy;
  logic [LEN_W-1:0]      w_len, r_gen_len;
  logic [USER_WIDTH-1:0] w_user, r_gen_user;
  logic [TMR_W-1:0]      r_tmr;
  logic [GAP_W-1:0]      r_gap;
  logic                  r_err_len, r_timeout;
  logic [31:0]           r_pkt_count;

  // aresetn in the enable keeps req_ready low while reset is held.
  assign w_arb_en = aresetn && enable && (r_state == S_IDLE);

  rr_arb #(.N(N_REQ), .W(SRC_W)) u_arb (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .i_en  (w_arb_en),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_len    = req_len[int'(w_idx)*LEN_W +: LEN_W];
  assign w_user   = req_user[int'(w_idx)*USER_WIDTH +: USER_WIDTH];
  assign w_len_ok = (w_len != '0) && (w_len <= LEN_W'(MTU_BYTES));
  assign w_legal  = w_any && w_len_ok;

  assign w_busy     = (r_state == S_ISSUE) || (r_state == S_WAIT_DONE);
  assign w_tmr_tc   = (r_tmr == '0);
  assign w_done_evt = gen_done && (((r_state == S_ISSUE) && gen_ack) || (r_state == S_WAIT_DONE));
  assign w_tmo_evt  = w_busy && w_tmr_tc && !w_done_evt;
  assign w_end      = w_done_evt || w_tmo_evt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_legal) w_state_nxt = S_ISSUE;
      S_ISSUE:     if (gen_ack) w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: w_state_nxt = S_WAIT_DONE;
      S_GAP:       if (r_gap == '0) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
    if (w_end) w_state_nxt = (cfg_gap == '0) ? S_IDLE : S_GAP;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_gen_len   <= '0;
      r_gen_user  <= '0;
      r_gen_src   <= '0;
      r_err_len   <= 1'b0;
      r_err_src   <= '0;
      r_timeout   <= 1'b0;
      r_pkt_count <= '0;
      r_tmr       <= '0;
      r_gap       <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_err_len <= w_any && !w_len_ok;
      r_timeout <= w_tmo_evt;
      if (w_any) begin
        r_rr_ptr <= (w_idx == SRC_W'(N_REQ - 1)) ? '0 : w_idx + SRC_W'(1);
        if (!w_len_ok) r_err_src <= w_idx;
      end
      if (w_legal) begin
        r_gen_len  <= w_len;
        r_gen_user <= w_user;
        r_gen_src  <= w_idx;
      end
      if (w_done_evt) r_pkt_count <= r_pkt_count + 32'd1;
      if (w_legal) r_tmr <= TMR_W'(DONE_TIMEOUT - 1);
      else if (w_busy && !w_tmr_tc) r_tmr <= r_tmr - TMR_W'(1);
      // Gap length is latched on entry so cfg_gap may change mid-gap.
      if (w_end && (cfg_gap != '0)) r_gap <= cfg_gap - GAP_W'(1);
      else if ((r_state == S_GAP) && (r_gap != '0)) r_gap <= r_gap - GAP_W'(1);
    end
  end

  assign req_ready = w_gnt;
  assign gen_req   = (r_state == S_ISSUE);
  assign gen_len   = r_gen_len;
  assign gen_user  = r_gen_user;
  assign gen_src   = r_gen_src;
  assign err_len   = r_err_len;
  assign err_src   = r_err_src;
  assign timeout   = r_timeout;
  assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_axis_pkt_sched.sv
// Directed bench for axis_pkt_sched: vector table for arbitration/length checks,
// hand sequences for reset, gap, timeout, disable and mid-packet reset.
module tb_axis_pkt_sched;

  localparam int N  = 4;
  localparam int LW = 11;
  localparam int UW = 8;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            aresetn = 1'b0;
  logic            enable = 1'b1;
  logic [15:0]     cfg_gap = '0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*LW-1:0] req_len = '0;
  logic [N*UW-1:0] req_user = 32'hA3A2_A1A0;
  logic            gen_req;
  logic            gen_ack = 1'b0;
  logic            gen_done = 1'b0;
  logic [LW-1:0]   gen_len;
  logic [UW-1:0]   gen_user;
  logic [SW-1:0]   gen_src;
  logic            err_len;
  logic [SW-1:0]   err_src;
  logic            timeout;
  logic [31:0]     pkt_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_pkt  = 0;

  typedef struct {
    logic [N-1:0]  valid;
    logic [LW-1:0] len;
    int            exp_src;
    bit            exp_err;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  axis_pkt_sched #(
    .N_REQ(N), .MTU_BYTES(1500), .USER_WIDTH(UW), .DONE_TIMEOUT(20)
  ) dut (
    .clk(clk), .aresetn(aresetn), .enable(enable), .cfg_gap(cfg_gap),
    .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len), .req_user(req_user),
    .gen_req(gen_req), .gen_ack(gen_ack), .gen_done(gen_done),
    .gen_len(gen_len), .gen_user(gen_user), .gen_src(gen_src),
    .err_len(err_len), .err_src(err_src), .timeout(timeout), .pkt_count(pkt_count)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_len(input logic [LW-1:0] l);
    req_len = {N{l}};
  endtask

  task automatic wait_ready(input string name, input int budget);
    int k = 0;
    #1;
    while (req_ready == '0 && k < budget) begin
      step();
      k++;
    end
    check({name, " grant seen"}, longint'(req_ready != '0), 1);
  endtask

  task automatic ack_done();
    gen_ack  = 1'b1;
    gen_done = 1'b1;
    step();
    gen_ack  = 1'b0;
    gen_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int grants;

    vecs[0]  = '{4'b1101, 11'd100,  2, 1'b0};
    vecs[1]  = '{4'b1101, 11'd200,  3, 1'b0};
    vecs[2]  = '{4'b1101, 11'd300,  0, 1'b0};
    vecs[3]  = '{4'b1101, 11'd400,  2, 1'b0};
    vecs[4]  = '{4'b1101, 11'd500,  3, 1'b0};
    vecs[5]  = '{4'b1101, 11'd600,  0, 1'b0};
    vecs[6]  = '{4'b0010, 11'd0,    1, 1'b1};
    vecs[7]  = '{4'b0100, 11'd1501, 2, 1'b1};
    vecs[8]  = '{4'b1111, 11'd1500, 3, 1'b0};
    vecs[9]  = '{4'b1111, 11'd1,    0, 1'b0};
    vecs[10] = '{4'b0001, 11'd7,    0, 1'b0};
    vecs[11] = '{4'b1010, 11'd64,   1, 1'b0};
    vecs[12] = '{4'b1001, 11'd65,   3, 1'b0};

    // Reset: outputs held at reset values despite all requests valid.
    req_valid = 4'b1111;
    set_len(11'd100);
    repeat (3) step();
    check("rst req_ready", req_ready, 0);
    check("rst gen_req", gen_req, 0);
    check("rst gen_len", gen_len, 0);
    check("rst gen_user", gen_user, 0);
    check("rst gen_src", gen_src, 0);
    check("rst err_len", err_len, 0);
    check("rst err_src", err_src, 0);
    check("rst timeout", timeout, 0);
    check("rst pkt_count", pkt_count, 0);
    aresetn = 1'b1;
    #1;
    check("first grant", req_ready, 4'b0001);
    step();
    req_valid = '0;
    check("first gen_req", gen_req, 1);
    check("first gen_src", gen_src, 0);
    check("first gen_len", gen_len, 100);
    ack_done();
    exp_pkt = 1;
    check("first pkt_count", pkt_count, exp_pkt);

    // Round-robin, illegal lengths and MTU boundaries.
    for (int i = 0; i < 13; i++) begin
      req_valid = vecs[i].valid;
      set_len(vecs[i].len);
      wait_ready($sformatf("vec%0d", i), 10);
      check($sformatf("vec%0d req_ready", i), req_ready, 1 << vecs[i].exp_src);
      step();
      req_valid = '0;
      if (vecs[i].exp_err) begin
        check($sformatf("vec%0d err_len", i), err_len, 1);
        check($sformatf("vec%0d err_src", i), err_src, vecs[i].exp_src);
        check($sformatf("vec%0d no gen_req", i), gen_req, 0);
      end else begin
        check($sformatf("vec%0d gen_req", i), gen_req, 1);
        check($sformatf("vec%0d gen_src", i), gen_src, vecs[i].exp_src);
        check($sformatf("vec%0d gen_len", i), gen_len, vecs[i].len);
        check($sformatf("vec%0d gen_user", i), gen_user, 8'hA0 + vecs[i].exp_src);
        ack_done();
        exp_pkt++;
        check($sformatf("vec%0d gen_req low", i), gen_req, 0);
      end
      check($sformatf("vec%0d pkt_count", i), pkt_count, exp_pkt);
    end

    // Gap of 5: next req_ready six cycles after gen_done; cfg_gap changed mid-gap.
    cfg_gap   = 16'd5;
    req_valid = 4'b0010;
    set_len(11'd50);
    wait_ready("gap", 10);
    check("gap req_ready", req_ready, 4'b0010);
    step();
    check("gap gen_req", gen_req, 1);
    gen_ack = 1'b1;
    step();
    gen_ack = 1'b0;
    check("gap gen_req falls after ack", gen_req, 0);
    step();
    step();
    gen_done = 1'b1;
    step();
    gen_done = 1'b0;
    cfg_gap  = 16'd0;
    exp_pkt++;
    k = 1;
    while (req_ready == '0 && k < 20) begin
      step();
      k++;
    end
    check("gap distance", k, 6);
    check("gap pkt_count", pkt_count, exp_pkt);
    check("gap regrant", req_ready, 4'b0010);
    step();
    req_valid = '0;
    check("gap second gen_req", gen_req, 1);
    ack_done();
    exp_pkt++;
    check("gap second pkt_count", pkt_count, exp_pkt);

    // Timeout: ack but no done; pulse 20 cycles after gen_req rose, then next requester.
    req_valid = 4'b1100;
    set_len(11'd80);
    wait_ready("tmo", 10);
    check("tmo req_ready", req_ready, 4'b0100);
    step();
    check("tmo gen_req", gen_req, 1);
    gen_ack = 1'b1;
    step();
    gen_ack = 1'b0;
    k = 1;
    while (!timeout && k < 40) begin
      step();
      k++;
    end
    check("tmo delay", k, 20);
    check("tmo gen_req low", gen_req, 0);
    check("tmo pkt_count", pkt_count, exp_pkt);
    check("tmo next grant", req_ready, 4'b1000);
    step();
    req_valid = '0;
    check("tmo pulse width", timeout, 0);
    check("tmo next gen_src", gen_src, 3);
    check("tmo next gen_req", gen_req, 1);
    ack_done();
    exp_pkt++;
    check("tmo next pkt_count", pkt_count, exp_pkt);

    // Disable during WAIT_DONE: packet completes, no new grant until re-enabled.
    req_valid = 4'b0011;
    set_len(11'd90);
    wait_ready("dis", 10);
    check("dis req_ready", req_ready, 4'b0001);
    step();
    check("dis gen_req", gen_req, 1);
    gen_ack = 1'b1;
    step();
    gen_ack = 1'b0;
    enable  = 1'b0;
    step();
    gen_done = 1'b1;
    step();
    gen_done = 1'b0;
    exp_pkt++;
    check("dis pkt_count", pkt_count, exp_pkt);
    grants = 0;
    repeat (5) begin
      if (req_ready != '0 || gen_req) grants++;
      step();
    end
    check("dis no grants", grants, 0);
    enable = 1'b1;
    #1;
    check("dis reenable grant", req_ready, 4'b0010);
    req_valid = '0;

    // Reset asserted while gen_req is high.
    req_valid = 4'b0001;
    set_len(11'd33);
    wait_ready("mrst", 10);
    check("mrst req_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    check("mrst gen_req", gen_req, 1);
    #2;
    aresetn = 1'b0;
    #1;
    check("mrst gen_req async", gen_req, 0);
    check("mrst gen_len", gen_len, 0);
    check("mrst pkt_count", pkt_count, 0);
    step();
    aresetn = 1'b1;
    step();
    check("mrst idle after release", gen_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
